// File: rtl/rf_wport_arbiter_if.sv
// Signal bundle between the pipeline (WB, LU, ID) and the register-file write-port arbiter.
// The arbiter side uses the slave modport; the pipeline side uses master.
interface rf_wport_arbiter_if;
   logic        wb_regwen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wdata;

   logic        lu_issue;
   logic [4:0]  lu_issue_rd;
   logic        lu_done;
   logic [4:0]  lu_rd;
   logic [31:0] lu_result;
   logic        lu_ready;

   logic        id_valid;
   logic [4:0]  id_ra1;
   logic [4:0]  id_ra2;
   logic [4:0]  id_rd;
   logic        id_sb_stall;

   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   logic        busy;
   logic        sb_overflow;

   modport master (
      output wb_regwen, wb_rd, wb_wdata,
      output lu_issue, lu_issue_rd, lu_done, lu_rd, lu_result,
      input  lu_ready,
      output id_valid, id_ra1, id_ra2, id_rd,
      input  id_sb_stall,
      input  rf_we, rf_wa, rf_wd,
      input  busy, sb_overflow
   );

   modport slave (
      input  wb_regwen, wb_rd, wb_wdata,
      input  lu_issue, lu_issue_rd, lu_done, lu_rd, lu_result,
      output lu_ready,
      input  id_valid, id_ra1, id_ra2, id_rd,
      output id_sb_stall,
      output rf_we, rf_wa, rf_wd,
      output busy, sb_overflow
   );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the register file's single write port between WB (priority) and a buffered LU result
// FIFO, and keeps a pending-destination scoreboard that stalls ID on RAW/WAW hazards.
module rf_wport_arbiter #(
   parameter int DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   rf_wport_arbiter_if.slave bus
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

   // FIFO storage and bookkeeping
   logic [4:0]    fifo_rd   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // Scoreboard and sticky error
   logic [31:0]   pending;
   logic          overflow_q;

   logic          wb_write;
   logic          fifo_empty;
   logic          fifo_ready;
   logic          push;
   logic          pop;
   logic          drop;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;
   logic [31:0]   set_vec;
   logic [31:0]   clr_vec;
   logic [31:0]   pending_next;

   logic          rf_we_c;
   logic [4:0]    rf_wa_c;
   logic [31:0]   rf_wd_c;

   function automatic logic reg_hit(input logic [4:0]  r,
                                    input logic [31:0] pend,
                                    input logic        iss,
                                    input logic [4:0]  iss_rd);
      return (r != 5'd0) && (pend[r] || (iss && (iss_rd == r)));
   endfunction

   assign wb_write   = bus.wb_regwen && (bus.wb_rd != 5'd0);
   assign fifo_empty = (count == '0);
   // A same-cycle pop does not free a slot for the incoming result.
   assign fifo_ready = (count < FULL_COUNT);
   assign push       = bus.lu_done && fifo_ready;
   assign drop       = bus.lu_done && !fifo_ready;
   assign pop        = !wb_write && !fifo_empty;
   assign head_rd    = fifo_rd[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

   // Write-port mux: WB first, then FIFO head; an rd=0 head drains silently.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch can be inferred.
      rf_we_c = 1'b0;
      rf_wa_c = head_rd;
      rf_wd_c = head_data;
      if (wb_write) begin
         rf_we_c = 1'b1;
         rf_wa_c = bus.wb_rd;
         rf_wd_c = bus.wb_wdata;
      end else if (!fifo_empty) begin
         rf_we_c = (head_rd != 5'd0);
      end
      if (rst) begin
         rf_we_c = 1'b0;
      end
   end

   assign bus.rf_we = rf_we_c;
   assign bus.rf_wa = rf_wa_c;
   assign bus.rf_wd = rf_wd_c;

   // Scoreboard update: clear on drain, set on issue; set is applied last so it wins.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (bus.lu_issue && (bus.lu_issue_rd != 5'd0)) begin
         set_vec[bus.lu_issue_rd] = 1'b1;
      end
      if (pop && (head_rd != 5'd0)) begin
         clr_vec[head_rd] = 1'b1;
      end
      pending_next = ((pending & ~clr_vec) | set_vec) & ~32'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // NOTE: the FIFO array is not reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= bus.lu_rd;
         fifo_data[wr_ptr] <= bus.lu_result;
      end
   end

   assign bus.lu_ready    = fifo_ready;
   assign bus.sb_overflow = overflow_q;
   assign bus.busy        = (|pending) || !fifo_empty;
   assign bus.id_sb_stall = !rst && bus.id_valid &&
                            (reg_hit(bus.id_ra1, pending, bus.lu_issue, bus.lu_issue_rd) ||
                             reg_hit(bus.id_ra2, pending, bus.lu_issue, bus.lu_issue_rd) ||
                             reg_hit(bus.id_rd,  pending, bus.lu_issue, bus.lu_issue_rd));

endmodule
